gemm_dot_sequencer: RTL
=======================

# gemm_dot_sequencer

Sequences one group-dot-product command through the GEMM tile buffers. The block accepts a command: left and right BRAM base addresses plus a native-vector count. It issues paired BRAM line reads, one 256-bit line per 32-element GFP8 group and four groups per 128-wide native vector. It then presents group-valid and framing flags to the dot-product engine, aligned with the returning BRAM data. It sits between the tile-load controller (command source) and the BRAM read ports and dot-product datapath.

## Interface
- ADDR_W, 9: BRAM line address width (BRAM_ADDR_WIDTH).
- GRP_PER_NV, 4: groups per native vector (NV_WIDTH/GROUP_SIZE); must be a power of two.
- RD_LAT, 1: BRAM read latency in cycles, range 1..4.
- NV_CNT_W, 8: width of native-vector count.

- i_clk, in, 1: clock.
- i_reset_n, in, 1: asynchronous active-low reset.
- i_cmd_valid, in, 1: command valid.
- o_cmd_ready, out, 1: command accepted when valid && ready.
- i_cmd_left_base, in, ADDR_W: left buffer base line.
- i_cmd_right_base, in, ADDR_W: right buffer base line.
- i_cmd_num_nv, in, NV_CNT_W: native vectors to process.
- i_dp_ready, in, 1: dot engine guarantees acceptance of a group RD_LAT cycles later.
- o_bram_rd_en, out, 1: read strobe for both buffers.
- o_bram_left_addr, o_bram_right_addr, out, ADDR_W: read line addresses.
- o_grp_valid, out, 1: BRAM data valid for dot engine.
- o_grp_idx, out, log2(GRP_PER_NV): group index within native vector.
- o_grp_first, o_grp_last, out, 1: first/last group of a native vector.
- o_nv_last, out, 1: group belongs to final native vector of command.
- o_busy, out, 1: state != IDLE.
- o_done, out, 1: single-cycle command completion pulse.

## Operation
- FSM states are IDLE, ISSUE, DRAIN, and DONE.
- IDLE: o_cmd_ready=1. On acceptance, the block latches bases and count, and clears the nv and grp counters. If num_nv==0, next state is DONE; otherwise next state is ISSUE.
- ISSUE: in each cycle with i_dp_ready=1:
  - rd_en=1.
  - left_addr = left_base + nv*GRP_PER_NV + grp, truncated to ADDR_W (wraps mod 2^ADDR_W); right_addr is computed the same way.
  - grp increments, and nv increments when grp wraps.
  - After the read for nv=num_nv-1 and grp=GRP_PER_NV-1, next state is DRAIN.
- ISSUE with i_dp_ready=0: rd_en=0, addresses hold, and counters hold.
- Framing flags (idx, first, last, nv_last) are computed at issue and delayed RD_LAT stages with rd_en to form o_grp_valid and the o_grp_* outputs.
- DRAIN: waits until the delay pipeline is empty (RD_LAT cycles after last issue), then goes to DONE.
- DONE: o_done=1 for one cycle, o_cmd_ready=0, then goes to IDLE.
- Commands presented while busy are not accepted; i_cmd_* are ignored outside IDLE.
- Reset mid-command discards all state and in-flight pipeline entries. No o_done is produced for the aborted command.

## Timing
- Reset values: o_cmd_ready=0 during reset and 1 after reset in IDLE. All other outputs are 0.
- Acceptance edge at cycle 0 gives the first o_bram_rd_en in cycle 1, provided i_dp_ready=1.
- o_grp_valid for a read issued in cycle k is asserted in cycle k+RD_LAT.
- Throughput is one group per cycle with no bubbles between native vectors.
- With i_dp_ready held high, command of N native vectors:
  - ISSUE spans cycles 1..4N.
  - DRAIN spans RD_LAT cycles.
  - o_done is asserted at cycle 4N+RD_LAT+1.
  - o_cmd_ready is high again at cycle 4N+RD_LAT+2.
- Zero-count command: o_done in cycle 1, ready in cycle 2.
- Address outputs are registered. They hold their last value when rd_en=0.

## Configuration
- GEMM_SEQ_PERF_EN defined: adds output o_stall_cnt (16 bits).
  - Counts ISSUE cycles with i_dp_ready=0 and saturates at 0xFFFF.
  - Clears to 0 on command acceptance.
  - Holds its value after o_done until the next command.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then idle: all outputs 0 during reset, o_cmd_ready=1 one cycle after release. No rd_en without a command.
- Command left_base=0x010, right_base=0x100, num_nv=2, ready high, RD_LAT=1:
  - Left addrs 0x010..0x017 and right addrs 0x100..0x107 over cycles 1..8.
  - o_grp_valid in cycles 2..9; first at idx0 and last at idx3; nv_last on the final 4 groups.
  - o_done in cycle 10.
- Wrap: left_base=0x1FE, num_nv=1 gives left addrs 0x1FE, 0x1FF, 0x000, 0x001.
- Backpressure: i_dp_ready toggling 1,0,1,0 produces reads only in ready cycles, no skipped or duplicated addresses, and o_stall_cnt equal to the number of low cycles when GEMM_SEQ_PERF_EN is defined.
- num_nv=0: no reads, o_done in cycle 1. Also cmd_valid held high during busy: exactly one acceptance per IDLE visit.
- Reset asserted mid-ISSUE (after 3 reads): outputs 0 immediately, no o_done. A new command after release runs normally from its base.

Source files
------------

// File: rtl/gemm_dot_sequencer.sv
// gemm_dot_sequencer: walks one group-dot-product command through the left/right tile
// BRAMs and frames returning groups for the dot engine. Optional: GEMM_SEQ_PERF_EN (stall counter).
module gemm_dot_sequencer #(
    parameter int ADDR_W     = 9,
    parameter int GRP_PER_NV = 4,
    parameter int RD_LAT     = 1,
    parameter int NV_CNT_W   = 8,
    localparam int IDX_W     = (GRP_PER_NV > 1) ? $clog2(GRP_PER_NV) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [ADDR_W-1:0]   i_cmd_left_base,
    input  logic [ADDR_W-1:0]   i_cmd_right_base,
    input  logic [NV_CNT_W-1:0] i_cmd_num_nv,
    input  logic                i_dp_ready,
    output logic                o_bram_rd_en,
    output logic [ADDR_W-1:0]   o_bram_left_addr,
    output logic [ADDR_W-1:0]   o_bram_right_addr,
    output logic                o_grp_valid,
    output logic [IDX_W-1:0]    o_grp_idx,
    output logic                o_grp_first,
    output logic                o_grp_last,
    output logic                o_nv_last,
    output logic                o_busy,
`ifdef GEMM_SEQ_PERF_EN
    output logic [15:0]         o_stall_cnt,
`endif
    output logic                o_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             is_first;
        logic             is_last;
        logic             nv_last;
    } grp_tag_t;

    state_t state, state_nx;

    logic                armed;
    logic [NV_CNT_W-1:0] num_nv_q;
    logic [NV_CNT_W-1:0] nv_q;
    logic [IDX_W-1:0]    grp_q;
    logic [ADDR_W-1:0]   left_addr_q;
    logic [ADDR_W-1:0]   right_addr_q;
    logic [2:0]          drain_cnt;

    logic                cmd_fire;
    logic                issue;
    logic                last_grp;
    logic                last_nv;
    logic                last_issue;
    grp_tag_t            tag_now;

    logic [RD_LAT-1:0]   vld_pipe;
    grp_tag_t            tag_pipe [RD_LAT];

    // armed keeps ready low through reset and for the first cycle after release.
    assign cmd_fire   = (state == IDLE) && armed && i_cmd_valid;
    assign issue      = (state == ISSUE) && i_dp_ready;
    assign last_grp   = (grp_q == IDX_W'(GRP_PER_NV - 1));
    assign last_nv    = (nv_q == num_nv_q - NV_CNT_W'(1));
    assign last_issue = issue && last_grp && last_nv;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        o_cmd_ready  = 1'b0;
        o_bram_rd_en = 1'b0;
        o_done       = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = armed;
                if (cmd_fire) state_nx = (i_cmd_num_nv == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                o_bram_rd_en = i_dp_ready;
                if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 3'(RD_LAT - 1)) state_nx = DONE;
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    // Sequential walk: address = base + nv*GRP_PER_NV + grp (mod 2^ADDR_W); holds on the final read.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            armed        <= 1'b0;
            num_nv_q     <= '0;
            nv_q         <= '0;
            grp_q        <= '0;
            left_addr_q  <= '0;
            right_addr_q <= '0;
            drain_cnt    <= '0;
        end else begin
            armed <= 1'b1;
            if (cmd_fire) begin
                num_nv_q     <= i_cmd_num_nv;
                nv_q         <= '0;
                grp_q        <= '0;
                left_addr_q  <= i_cmd_left_base;
                right_addr_q <= i_cmd_right_base;
            end else if (issue && !last_issue) begin
                grp_q        <= grp_q + IDX_W'(1);
                if (last_grp) nv_q <= nv_q + NV_CNT_W'(1);
                left_addr_q  <= left_addr_q + ADDR_W'(1);
                right_addr_q <= right_addr_q + ADDR_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    assign o_bram_left_addr  = left_addr_q;
    assign o_bram_right_addr = right_addr_q;

    always_comb begin
        tag_now = '0;
        if (issue) begin
            tag_now.idx      = grp_q;
            tag_now.is_first = (grp_q == '0);
            tag_now.is_last  = last_grp;
            tag_now.nv_last  = last_nv;
        end
    end

    // NOTE: the tag pipeline is reset with its valid bits so framing reads 0 in reset and aborted groups vanish.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= issue;
            tag_pipe[0] <= tag_now;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign o_grp_valid = vld_pipe[RD_LAT-1];
    assign o_grp_idx   = tag_pipe[RD_LAT-1].idx;
    assign o_grp_first = tag_pipe[RD_LAT-1].is_first;
    assign o_grp_last  = tag_pipe[RD_LAT-1].is_last;
    assign o_nv_last   = tag_pipe[RD_LAT-1].nv_last;

`ifdef GEMM_SEQ_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt <= '0;
        end else if (cmd_fire) begin
            stall_cnt <= '0;
        end else if ((state == ISSUE) && !i_dp_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule
